// File: rtl/scan_sequencer.sv
// Bidirectional LED scanner: sweeps a one-hot LED up and down with end dwell, button-selected rate and pause.
// Define SCAN_PWM_EN to add a 4-bit brightness PWM on the LED drive, cycled by btn_bright.
module scan_sequencer #(
    parameter int WIDTH       = 8,
    parameter int CLK_FREQ    = 6000,
    parameter int DWELL_TICKS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_rate,
    input  logic                     btn_hold,
    input  logic                     btn_bright,
    output logic                     step,
    output logic                     dir,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic [2:0]               rate_sel,
    output logic [WIDTH-1:0]         led
);
    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_LAST   = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_ONE    = PW'(1);
    localparam logic [3:0]    DWELL_LAST = 4'(DWELL_TICKS - 1);
    localparam logic [13:0]   MAX0 = 14'(2 * CLK_FREQ - 1);
    localparam logic [13:0]   MAX1 = 14'(CLK_FREQ - 1);
    localparam logic [13:0]   MAX2 = 14'(CLK_FREQ / 2 - 1);
    localparam logic [13:0]   MAX3 = 14'(CLK_FREQ / 4 - 1);
    localparam logic [13:0]   MAX4 = 14'(CLK_FREQ / 8 - 1);

    typedef enum logic [2:0] {SCAN_UP, DWELL_TOP, SCAN_DN, DWELL_BOT, HOLD} state_t;

`ifdef SCAN_PWM_EN
    localparam int NB = 3;
    logic [NB-1:0] w_btn;
    assign w_btn = {btn_bright, btn_hold, btn_rate};
`else
    localparam int NB = 2;
    logic [NB-1:0] w_btn;
    logic          w_unused_bright;
    assign w_btn           = {btn_hold, btn_rate};
    assign w_unused_bright = btn_bright;
`endif

    // Two synchronizer stages, a delayed copy for edge detect, and a registered pulse.
    logic [NB-1:0] r_sync1, r_sync2, r_sync3, r_pulse;
    logic          w_rate_p, w_hold_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_pulse <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pulse <= r_sync2 & ~r_sync3;
        end
    end

    assign w_rate_p = r_pulse[0];
    assign w_hold_p = r_pulse[1];

    state_t        r_state, r_saved, w_state_nxt, w_saved_nxt;
    logic [PW-1:0] r_pos, w_pos_nxt, w_pos_inc, w_pos_dec;
    logic          r_dir, w_dir_nxt;
    logic          r_step, w_step_nxt;
    logic [3:0]    r_dwell, w_dwell_nxt;
    logic [2:0]    r_rate;
    logic [13:0]   r_tick_cnt, w_max;
    logic          w_tick;

    always_comb begin
        case (r_rate)
            3'd0:    w_max = MAX0;
            3'd1:    w_max = MAX1;
            3'd3:    w_max = MAX3;
            3'd4:    w_max = MAX4;
            default: w_max = MAX2;
        endcase
    end

    // >= rather than == so a rate change that shrinks the period cannot skip the tick.
    assign w_tick = (r_state != HOLD) && (r_tick_cnt >= w_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_rate     <= 3'd2;
        end else begin
            if (r_state != HOLD)
                r_tick_cnt <= w_tick ? 14'd0 : r_tick_cnt + 14'd1;
            if (w_rate_p)
                r_rate <= (r_rate == 3'd4) ? 3'd0 : r_rate + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SCAN_UP;
            r_saved <= SCAN_UP;
            r_pos   <= '0;
            r_dir   <= 1'b1;
            r_step  <= 1'b0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
            r_step  <= w_step_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    assign w_pos_inc = r_pos + POS_ONE;
    assign w_pos_dec = r_pos - POS_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        w_dwell_nxt = r_dwell;
        // A hold pulse wins over a coincident tick, which is simply dropped.
        if (w_hold_p) begin
            if (r_state == HOLD) begin
                w_state_nxt = r_saved;
            end else begin
                w_saved_nxt = r_state;
                w_state_nxt = HOLD;
            end
        end else if (w_tick) begin
            case (r_state)
                SCAN_UP: begin
                    w_pos_nxt  = w_pos_inc;
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = 1'b1;
                    if (w_pos_inc == POS_LAST)
                        w_state_nxt = DWELL_TOP;
                end
                SCAN_DN: begin
                    w_pos_nxt  = w_pos_dec;
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = 1'b0;
                    if (w_pos_dec == '0)
                        w_state_nxt = DWELL_BOT;
                end
                DWELL_TOP, DWELL_BOT: begin
                    if (r_dwell == DWELL_LAST) begin
                        w_dwell_nxt = '0;
                        w_dir_nxt   = ~r_dir;
                        w_state_nxt = (r_state == DWELL_TOP) ? SCAN_DN : SCAN_UP;
                    end else begin
                        w_dwell_nxt = r_dwell + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [WIDTH-1:0] w_onehot;
    assign w_onehot = WIDTH'(1) << r_pos;

`ifdef SCAN_PWM_EN
    logic [3:0] r_pwm_cnt, r_duty;

    // Duty steps down by 4 and wraps 3 -> 15 through natural 4-bit overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_duty    <= 4'd15;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (r_pulse[2])
                r_duty <= r_duty - 4'd4;
        end
    end

    assign led = (r_pwm_cnt < r_duty) ? w_onehot : '0;
`else
    assign led = w_onehot;
`endif

    assign step     = r_step;
    assign dir      = r_dir;
    assign pos      = r_pos;
    assign rate_sel = r_rate;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer at CLK_FREQ=16, WIDTH=8, DWELL_TICKS=2 (tick maxima 31/15/7/3/1).
// Expected step spacings are hand-derived from the 3-edge button latency and the tick counter.
module tb_scan_sequencer;
    logic       clk = 1'b0;
    logic       reset, btn_rate, btn_hold, btn_bright;
    logic       step, dir;
    logic [2:0] pos, rate_sel;
    logic [7:0] led;

    int n_assert = 0;
    int n_fail   = 0;
    int c, seen;

    scan_sequencer #(.WIDTH(8), .CLK_FREQ(16), .DWELL_TICKS(2)) dut (
        .clk(clk), .reset(reset), .btn_rate(btn_rate), .btn_hold(btn_hold),
        .btn_bright(btn_bright), .step(step), .dir(dir), .pos(pos),
        .rate_sel(rate_sel), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // With PWM enabled the drive may be blanked in the sampled cycle.
    task automatic chk_led(input string tag, input logic [7:0] exp);
        logic [7:0] l;
        l = led;
`ifdef SCAN_PWM_EN
        if (l == 8'h00) l = exp;
`endif
        chk(tag, {24'd0, l}, {24'd0, exp});
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step !== 1'b1 && n < 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; btn_rate = 1'b0; btn_hold = 1'b0; btn_bright = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos", pos, 0);
        chk("rst_dir", dir, 1);
        chk("rst_step", step, 0);
        chk("rst_rate", rate_sel, 2);
        chk("rst_led", led, 8'h01);
        reset = 1'b0;

        // Scan up at rate 2: one step every 8 cycles.
        for (int k = 1; k <= 7; k++) begin
            wait_step(c);
            chk("up_period", c, 8);
            chk("up_pos", pos, k);
        end
        wait_step(c);
        chk("dwell_top_gap", c, 24);
        chk("turn_pos", pos, 6);
        chk("turn_dir", dir, 0);
        chk_led("turn_led", 8'h40);

        // Asynchronous reset while scanning down.
        #2 reset = 1'b1;
        #1;
        chk("arst1_pos", pos, 0);
        chk("arst1_dir", dir, 1);
        chk("arst1_led", led, 8'h01);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) wait_step(c);
        chk("up2_pos", pos, 7);

        // Reset in the middle of the top dwell.
        repeat (12) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst2_pos", pos, 0);
        chk("arst2_dir", dir, 1);
        chk("arst2_step", step, 0);
        chk("arst2_rate", rate_sel, 2);
        chk("arst2_led", led, 8'h01);
        @(negedge clk);
        reset = 1'b0;
        wait_step(c);
        chk("post_rst_period", c, 8);
        chk("post_rst_pos", pos, 1);
        chk("post_rst_dir", dir, 1);

        // Rate presses: 2 -> 3 -> 4 -> 0.
        btn_rate = 1'b1;
        wait_step(c);
        chk("rate3_first", c, 5);
        chk("rate3_sel", rate_sel, 3);
        wait_step(c);
        chk("rate3_period", c, 4);
        chk("rate3_pos", pos, 3);
        btn_rate = 1'b0;
        wait_step(c);
        chk("rate3_period2", c, 4);
        btn_rate = 1'b1;
        wait_step(c);
        chk("rate4_first", c, 4);
        chk("rate4_sel", rate_sel, 4);
        btn_rate = 1'b0;
        wait_step(c);
        chk("rate4_period", c, 2);
        chk("rate4_pos", pos, 6);
        btn_rate = 1'b1;
        wait_step(c);
        chk("rate4_period2", c, 2);
        chk("rate4_pos7", pos, 7);
        wait_step(c);
        chk("rate0_dwell_gap", c, 66);
        chk("rate0_sel", rate_sel, 0);
        chk("rate0_pos", pos, 6);
        chk("rate0_dir", dir, 0);
        btn_rate = 1'b0;
        for (int k = 5; k >= 3; k--) begin
            wait_step(c);
            chk("rate0_period", c, 32);
            chk("rate0_pos_dn", pos, k);
        end

        // Pause at pos 3, then resume with the remaining count.
        btn_hold = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 10) btn_hold = 1'b0;
            if (step) seen++;
        end
        chk("hold_no_step", seen, 0);
        chk("hold_pos", pos, 3);
        chk_led("hold_led", 8'h08);
        btn_hold = 1'b1;
        wait_step(c);
        chk("resume_period", c, 32);
        chk("resume_pos", pos, 2);
        btn_hold = 1'b0;

        // Hold pulse lands in the same cycle as a tick: the tick is dropped.
        repeat (28) @(negedge clk);
        btn_hold = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 10) btn_hold = 1'b0;
            if (step) seen++;
        end
        chk("hold_tick_no_step", seen, 0);
        chk("hold_tick_pos", pos, 2);
        btn_hold = 1'b1;
        wait_step(c);
        chk("hold_tick_resume", c, 36);
        chk("hold_tick_resume_pos", pos, 1);
        btn_hold = 1'b0;

        // Brightness: two presses.
        btn_bright = 1'b1; repeat (5) @(negedge clk);
        btn_bright = 1'b0; repeat (5) @(negedge clk);
        btn_bright = 1'b1; repeat (5) @(negedge clk);
        btn_bright = 1'b0; repeat (2) @(negedge clk);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led != 8'h00) seen++;
        end
`ifdef SCAN_PWM_EN
        chk("pwm_on_cycles", seen, 7);
`else
        chk("led_on_cycles", seen, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of LEDs scanned (4..16).
REQ-002 The block SHALL have parameter CLK_FREQ, default 6000: clock frequency in Hz, used to derive tick periods.
REQ-003 The block SHALL have parameter DWELL_TICKS, default 2: number of ticks held at each end before reversing (1..15).
REQ-004 The block SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port btn_rate, input, 1: raw asynchronous button that cycles the scan rate.
REQ-007 The block SHALL have port btn_hold, input, 1: raw asynchronous button that toggles pause.
REQ-008 The block SHALL have port btn_bright, input, 1: raw asynchronous button that cycles brightness (used only under REQ-029).
REQ-009 The block SHALL have port step, output, 1: registered one-cycle pulse each time pos moves.
REQ-010 The block SHALL have port dir, output, 1: current direction, 1 = increasing pos, 0 = decreasing.
REQ-011 The block SHALL have port pos, output, clog2(WIDTH): index of the active LED.
REQ-012 The block SHALL have port rate_sel, output, 3: current rate index (0 = slowest .. 4 = fastest).
REQ-013 The block SHALL have port led, output, WIDTH: the one-hot LED drive.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer plus a 1-flop edge register. A rising edge SHALL yield exactly one 1-cycle pulse, asserted in the cycle after the 3rd rising clk edge that samples the input high. A held level SHALL produce no further pulses.
REQ-015 The rate pulse SHALL advance rate_sel 0->1->2->3->4->0.
REQ-016 Tick period maxima SHALL be: rate_sel 0 = 2*CLK_FREQ-1, 1 = CLK_FREQ-1, 2 = CLK_FREQ/2-1, 3 = CLK_FREQ/4-1, 4 = CLK_FREQ/8-1 (integer division).
REQ-017 The 14-bit tick counter SHALL increment every cycle unless in HOLD. When counter >= max, tick SHALL be asserted combinationally and the counter SHALL clear to 0. The >= compare covers a max that shrinks mid-count.
REQ-018 The FSM states SHALL be SCAN_UP, DWELL_TOP, SCAN_DN, DWELL_BOT and HOLD.
REQ-019 In SCAN_UP, on tick: pos increments, step pulses, and dir = 1. When the new pos equals WIDTH-1, the FSM SHALL go to DWELL_TOP.
REQ-020 In SCAN_DN, on tick: pos decrements, step pulses, and dir = 0. When the new pos equals 0, the FSM SHALL go to DWELL_BOT.
REQ-021 In DWELL_TOP and DWELL_BOT, the 4-bit dwell counter SHALL count ticks without moving pos. After DWELL_TICKS ticks it SHALL clear, toggle dir, and go to SCAN_DN or SCAN_UP respectively.
REQ-022 The hold pulse in any non-HOLD state SHALL save that state and enter HOLD. While in HOLD: tick counter frozen, dwell counter frozen, step = 0, pos unchanged. The hold pulse in HOLD SHALL return to the saved state with the counters unchanged.
REQ-023 A rate pulse in the same cycle as a tick SHALL update rate_sel and still take the tick. Rate pulses in HOLD SHALL update rate_sel.
REQ-024 A hold pulse in the same cycle as a tick SHALL enter HOLD and discard the tick: no step, pos unchanged.
REQ-025 pos SHALL never leave the range 0..WIDTH-1. led SHALL be one-hot(pos), gated only per REQ-029.
REQ-026 Latency: tick at cycle N SHALL give step, pos and led updated at edge N+1.

Reset
REQ-027 While reset = 1, asynchronously: state = SCAN_UP, pos = 0, dir = 1, step = 0, rate_sel = 2, tick counter = 0, dwell counter = 0, all synchronizer flops = 0, led = 1 (bit 0), and under REQ-029 duty = 15.
REQ-028 Reset asserted mid-dwell or in HOLD SHALL discard the saved state. The first tick after release SHALL move pos 0->1.

Configuration
REQ-029 With SCAN_PWM_EN defined: a 4-bit free-running PWM counter and a 4-bit duty register are present. The bright pulse SHALL cycle duty 15->11->7->3->15. led SHALL equal one-hot(pos) when pwm_cnt < duty, otherwise 0.
REQ-030 With SCAN_PWM_EN undefined: btn_bright SHALL be ignored, no PWM logic is present, and led SHALL equal one-hot(pos) at all times.

Verification (CLK_FREQ=16, WIDTH=8, DWELL_TICKS=2; maxima 31/15/7/3/1)
REQ-031 Reset release -> step every 8 cycles; pos 0..7 in 56 cycles; pos holds 7 for 2 ticks; pos 6 with dir = 0 on the 3rd tick after reaching 7.
REQ-032 Three btn_rate presses -> rate_sel 2->3->4->0; step periods 4, 2, 32 cycles.
REQ-033 Raise btn_hold at pos = 3 -> no step for 100 cycles, pos = 3; second press -> the next step arrives after exactly the remaining count.
REQ-034 Assert reset mid DWELL_TOP -> outputs per REQ-027 immediately, without a clock edge; the next tick moves pos to 1 with dir = 1.
REQ-035 SCAN_PWM_EN defined, btn_bright pressed twice -> duty = 7; led high 7 of every 16 cycles.
REQ-036 btn_hold rising in the same cycle as a tick -> no step, HOLD entered, pos unchanged.
